cu_seq: RTL and testbench

CU_SEQ -- requirements
Module: cu_seq

---
 rtl/cu_pkg.sv | 24 ++
 rtl/cu_mem_hs.sv | 39 +++
 rtl/cu_seq.sv | 184 ++++++++++++++++++
 tb/tb_cu_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit sequencer.
// Included by the sequencer top and its memory handshake block.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    LOAD_IR   = 3'd1,
    PHASE     = 3'd2,
    WAIT_MEM  = 3'd3,
    UPDATE_PC = 3'd4
  } state_t;

  localparam logic [7:0] FETCH_FIN = 8'h50;
  localparam logic [3:0] MEM_IN    = 4'd1;
  localparam logic [2:0] MEM_OUT   = 3'd5;
  localparam logic [2:0] MEM_OUT2  = 3'd6;
  localparam logic [7:0] RETI      = 8'hFF;

  // A microcode word needs the memory engine for an operand fetch or any memory in/out selector.
  function automatic logic needs_mem(input logic [7:0] uc);
    return uc[7] | (uc[3:0] == MEM_IN) | (uc[6:4] == MEM_OUT) | (uc[6:4] == MEM_OUT2);
  endfunction

endpackage

// File: rtl/cu_mem_hs.sv
// Memory request/completion handshake for the sequencer.
// A completion seen while the sequencer is frozen is held until it can be consumed.
module cu_mem_hs
  import cu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  logic req_set,
  input  logic req_clr,
  input  logic mem_done,
  output logic mem_req,
  output logic done
);

  logic mem_req_r;
  logic done_lat_r;

  assign mem_req = mem_req_r;
  assign done    = mem_req_r & (mem_done | done_lat_r);

  // Request register and frozen-completion latch.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r  <= 1'b0;
      done_lat_r <= 1'b0;
    end else if (freeze) begin
      if (mem_req_r && mem_done) begin
        done_lat_r <= 1'b1;
      end
    end else if (req_clr) begin
      mem_req_r  <= 1'b0;
      done_lat_r <= 1'b0;
    end else if (req_set) begin
      mem_req_r  <= 1'b1;
    end
  end

endmodule

// File: rtl/cu_seq.sv
// Instruction sequencer: fetch, microcode phases, memory waits and PC update,
// with halt/single-step and a single maskable interrupt vector.
module cu_seq
  import cu_pkg::*;
#(
  parameter int              PC_W    = 16,
  parameter int              IR_W    = 8,
  parameter int              PHASES  = 2,
  parameter logic [PC_W-1:0] IRQ_VEC = PC_W'(16'h0004)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            step,
  input  logic            mem_done,
  output logic            mem_req,
  input  logic [IR_W-1:0] irin,
  output logic [1:0]      uc_phase,
  output logic [IR_W-1:0] uc_addr,
  input  logic [7:0]      uc_data,
  input  logic            pcinflag,
  input  logic [PC_W-1:0] pcin,
  input  logic            irq,
  output logic            irq_ack,
  output logic [PC_W-1:0] pc,
  output logic            en,
  output logic [3:0]      inflags,
  output logic [2:0]      outflags,
  output logic [IR_W-1:0] cuout,
  output logic            busy
);

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [IR_W-1:0] ir_r;
  logic [6:0]      fin_r;
  logic [1:0]      ph_r;
  logic            ie_r;
  logic            irq_ack_r;
  logic            armed_r;
  logic            step_q_r;

  logic freeze_s;
  logic need_mem_s;
  logic last_ph_s;
  logic done_s;
  logic mem_req_s;
  logic req_set_s;
  logic req_clr_s;

  assign freeze_s   = halt & ~armed_r;
  assign need_mem_s = needs_mem(uc_data);
  assign last_ph_s  = (ph_r == 2'(PHASES - 1));

  assign mem_req  = mem_req_s;
  assign uc_phase = ph_r;
  assign uc_addr  = ir_r;
  assign cuout    = ir_r;
  assign pc       = pc_r;
  assign irq_ack  = irq_ack_r;
  assign inflags  = fin_r[3:0];
  assign outflags = fin_r[6:4];
  assign busy     = (state_r != FETCH);
  assign en       = (state_r == PHASE) | (state_r == UPDATE_PC);

  cu_mem_hs u_mem_hs (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze_s),
    .req_set  (req_set_s),
    .req_clr  (req_clr_s),
    .mem_done (mem_done),
    .mem_req  (mem_req_s),
    .done     (done_s)
  );

  // Raise/drop requests for the handshake block; the fetch request is raised on the first FETCH cycle.
  always_comb begin
    req_set_s = 1'b0;
    req_clr_s = 1'b0;
    case (state_r)
      FETCH: begin
        req_set_s = ~mem_req_s;
        req_clr_s = done_s;
      end
      PHASE:    req_set_s = need_mem_s;
      WAIT_MEM: req_clr_s = done_s;
      default: begin
        req_set_s = 1'b0;
        req_clr_s = 1'b0;
      end
    endcase
  end

  // Step edge detection; the armed flag lets one instruction run under halt until FETCH is re-entered.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      step_q_r <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      step_q_r <= step;
      if ((state_r == UPDATE_PC) && !freeze_s) begin
        armed_r <= 1'b0;
      end else if (halt && step && !step_q_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Main sequencer state machine.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FETCH;
      pc_r      <= '0;
      ir_r      <= '0;
      fin_r     <= 7'd0;
      ph_r      <= 2'd0;
      ie_r      <= 1'b1;
      irq_ack_r <= 1'b0;
    end else begin
      irq_ack_r <= 1'b0;
      if (!freeze_s) begin
        case (state_r)
          FETCH: begin
            fin_r <= FETCH_FIN[6:0];
            if (done_s) begin
              state_r <= LOAD_IR;
            end
          end
          LOAD_IR: begin
            fin_r   <= 7'd0;
            ir_r    <= irin;
            ph_r    <= 2'd0;
            state_r <= PHASE;
          end
          PHASE: begin
            fin_r <= uc_data[6:0];
            if (uc_data[7]) begin
              pc_r <= pc_r + PC_W'(1);
            end
            if (need_mem_s) begin
              state_r <= WAIT_MEM;
            end else if (!last_ph_s) begin
              ph_r <= ph_r + 2'd1;
            end else begin
              state_r <= UPDATE_PC;
            end
          end
          WAIT_MEM: begin
            if (done_s) begin
              if (!last_ph_s) begin
                ph_r    <= ph_r + 2'd1;
                state_r <= PHASE;
              end else begin
                state_r <= UPDATE_PC;
              end
            end
          end
          UPDATE_PC: begin
            // A taken interrupt masks further interrupts until a RETI completes.
            if (irq && ie_r) begin
              pc_r      <= IRQ_VEC;
              irq_ack_r <= 1'b1;
              ie_r      <= 1'b0;
            end else begin
              if (ir_r == IR_W'(RETI)) begin
                ie_r <= 1'b1;
              end
              if (pcinflag) begin
                pc_r <= pcin;
              end else begin
                pc_r <= pc_r + PC_W'(1);
              end
            end
            fin_r   <= FETCH_FIN[6:0];
            state_r <= FETCH;
          end
          default: state_r <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cu_seq.sv
// Directed self-checking bench for cu_seq: sequencing, operands, jumps/irq,
// PC wrap, halt with latched completion, single-step and mid-transfer reset.
module tb_cu_seq;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, halt, step, mem_done, pcinflag, irq;
  logic [7:0]  irin, uc_data, uc_addr, cuout;
  logic [1:0]  uc_phase;
  logic [15:0] pcin, pc;
  logic        mem_req, irq_ack, en, busy;
  logic [3:0]  inflags;
  logic [2:0]  outflags;

  logic [7:0]  uc0, uc1;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat_cnt = 0;
  state_t      trace[$];
  int          req_cnt, ack_cnt;
  logic [6:0]  upd_fin;
  logic        req_prev;

  always #5 clk = ~clk;

  // External microcode ROM: one word per phase, independent of the opcode.
  assign uc_data = (uc_phase == 2'd0) ? uc0 : uc1;

  cu_seq dut (
    .clk(clk), .rst(rst), .halt(halt), .step(step), .mem_done(mem_done),
    .mem_req(mem_req), .irin(irin), .uc_phase(uc_phase), .uc_addr(uc_addr),
    .uc_data(uc_data), .pcinflag(pcinflag), .pcin(pcin), .irq(irq),
    .irq_ack(irq_ack), .pc(pc), .en(en), .inflags(inflags),
    .outflags(outflags), .cuout(cuout), .busy(busy)
  );

  // Memory engine model: pulses mem_done lat cycles after seeing mem_req (called at posedge).
  task automatic serve_tick(input int lat);
    if (mem_done) mem_done = 1'b0;
    else if (mem_req) begin
      if (lat_cnt >= lat) begin mem_done = 1'b1; lat_cnt = 0; end
      else lat_cnt++;
    end else lat_cnt = 0;
  endtask

  task automatic run_instr(input logic [7:0] op, input logic [7:0] u0, input logic [7:0] u1, input int lat);
    logic seen, ok;
    seen = busy; ok = 1'b0;
    irin = op; uc0 = u0; uc1 = u1;
    trace.delete(); req_cnt = 0; ack_cnt = 0; req_prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (mem_req && !req_prev) req_cnt++;
      req_prev = mem_req;
      if (irq_ack) ack_cnt++;
      if (dut.state_r == UPDATE_PC) upd_fin = {outflags, inflags};
      if (busy) begin seen = 1'b1; trace.push_back(dut.state_r); end
      else if (seen) begin ok = 1'b1; break; end
      serve_tick(lat);
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL run_instr_timeout op=%h got no FETCH return want return", op); end
  endtask

  task automatic advance_to(input state_t tgt, input int lat);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (dut.state_r == tgt) begin hit = 1'b1; break; end
      serve_tick(lat);
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL advance_timeout got %0d want %0d", int'(dut.state_r), int'(tgt)); end
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; step = 1'b0; mem_done = 1'b0; pcinflag = 1'b0; irq = 1'b0;
    irin = 8'h00; pcin = 16'h0000; uc0 = 8'h00; uc1 = 8'h00;
    repeat (3) @(posedge clk);
    n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc got %h want 0000", pc); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    n_cmp++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL rst_irq_ack got %b want 0", irq_ack); end
    n_cmp++; if ({busy, en} !== 2'b00) begin n_fail++; $display("FAIL rst_busy_en got %b want 00", {busy, en}); end
    n_cmp++; if ({cuout, uc_phase, outflags, inflags} !== 17'd0) begin n_fail++; $display("FAIL rst_regs got %h want 0", {cuout, uc_phase, outflags, inflags}); end
    n_cmp++; if (dut.ie_r !== 1'b1) begin n_fail++; $display("FAIL rst_ie got %b want 1", dut.ie_r); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    pcinflag = 1'b1; pcin = 16'h0010;
    run_instr(8'h20, 8'h00, 8'h00, 0);
    n_cmp++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL setup_pc got %h want 0010", pc); end
    pcinflag = 1'b0;
    run_instr(8'h21, 8'h00, 8'h00, 3);
    n_cmp++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL basic_pc got %h want 0011", pc); end
    n_cmp++; if (req_cnt !== 1) begin n_fail++; $display("FAIL basic_reqs got %0d want 1", req_cnt); end
    n_cmp++; if (trace.size() !== 4) begin n_fail++; $display("FAIL basic_trace_len got %0d want 4", trace.size()); end
    else begin
      n_cmp++; if (trace[0] !== LOAD_IR || trace[1] !== PHASE || trace[2] !== PHASE || trace[3] !== UPDATE_PC) begin
        n_fail++; $display("FAIL basic_trace got %0d %0d %0d %0d want 1 2 2 4", int'(trace[0]), int'(trace[1]), int'(trace[2]), int'(trace[3]));
      end
    end
    n_cmp++; if ({cuout, uc_addr} !== 16'h2121) begin n_fail++; $display("FAIL basic_ir got %h want 2121", {cuout, uc_addr}); end
  endtask

  task automatic test_operand();
    run_instr(8'h30, 8'h80, 8'h00, 1);
    n_cmp++; if (pc !== 16'h0013) begin n_fail++; $display("FAIL operand_pc got %h want 0013", pc); end
    n_cmp++; if (req_cnt !== 2) begin n_fail++; $display("FAIL operand_reqs got %0d want 2", req_cnt); end
    run_instr(8'h31, 8'h62, 8'h03, 0);
    n_cmp++; if ({pc, 7'(req_cnt), upd_fin} !== {16'h0014, 7'd2, 7'h03}) begin n_fail++; $display("FAIL memout2 got pc=%h reqs=%0d fin=%h want 0014 2 03", pc, req_cnt, upd_fin); end
    run_instr(8'h32, 8'h01, 8'h50, 0);
    n_cmp++; if ({pc, 7'(req_cnt), upd_fin} !== {16'h0015, 7'd3, 7'h50}) begin n_fail++; $display("FAIL memin_out got pc=%h reqs=%0d fin=%h want 0015 3 50", pc, req_cnt, upd_fin); end
  endtask

  task automatic test_jump_irq();
    pcinflag = 1'b1; pcin = 16'h1234;
    run_instr(8'h40, 8'h00, 8'h00, 0);
    n_cmp++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL jump_pc got %h want 1234", pc); end
    irq = 1'b1;
    run_instr(8'h41, 8'h00, 8'h00, 0);
    n_cmp++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL irq_pc got %h want 0004", pc); end
    n_cmp++; if (ack_cnt !== 1) begin n_fail++; $display("FAIL irq_ack_cnt got %0d want 1", ack_cnt); end
    n_cmp++; if (dut.ie_r !== 1'b0) begin n_fail++; $display("FAIL irq_ie got %b want 0", dut.ie_r); end
    @(posedge clk);
    n_cmp++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_ack_pulse got %b want 0", irq_ack); end
    pcinflag = 1'b0;
    run_instr(8'h42, 8'h00, 8'h00, 0);
    n_cmp++; if ({pc, 7'(ack_cnt)} !== {16'h0005, 7'd0}) begin n_fail++; $display("FAIL irq_masked got pc=%h acks=%0d want 0005 0", pc, ack_cnt); end
    irq = 1'b0;
    run_instr(8'hFF, 8'h00, 8'h00, 0);
    n_cmp++; if ({pc, dut.ie_r} !== {16'h0006, 1'b1}) begin n_fail++; $display("FAIL reti got pc=%h ie=%b want 0006 1", pc, dut.ie_r); end
  endtask

  task automatic test_wrap();
    pcinflag = 1'b1; pcin = 16'hFFFF;
    run_instr(8'h43, 8'h00, 8'h00, 0);
    pcinflag = 1'b0;
    run_instr(8'h44, 8'h00, 8'h00, 0);
    n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got %h want 0000", pc); end
  endtask

  task automatic test_halt();
    irin = 8'h50; uc0 = 8'h80; uc1 = 8'h00;
    advance_to(WAIT_MEM, 0);
    halt = 1'b1;
    @(posedge clk); mem_done = 1'b1;
    @(posedge clk); mem_done = 1'b0;
    repeat (3) @(posedge clk);
    n_cmp++; if (dut.state_r !== WAIT_MEM || mem_req !== 1'b1 || pc !== 16'h0001) begin
      n_fail++; $display("FAIL halt_hold got st=%0d req=%b pc=%h want 3 1 0001", int'(dut.state_r), mem_req, pc);
    end
    halt = 1'b0;
    @(posedge clk);
    n_cmp++; if (dut.state_r !== PHASE || uc_phase !== 2'd1) begin n_fail++; $display("FAIL halt_resume got st=%0d ph=%0d want 2 1", int'(dut.state_r), uc_phase); end
    run_instr(8'h50, 8'h80, 8'h00, 0);
    n_cmp++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL halt_pc got %h want 0002", pc); end
  endtask

  task automatic test_step();
    halt = 1'b1;
    repeat (3) @(posedge clk);
    n_cmp++; if ({busy, mem_req} !== 2'b00) begin n_fail++; $display("FAIL step_stall got %b want 00", {busy, mem_req}); end
    step = 1'b1; @(posedge clk); step = 1'b0;
    run_instr(8'h60, 8'h00, 8'h00, 0);
    n_cmp++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL step_pc got %h want 0003", pc); end
    repeat (4) @(posedge clk);
    n_cmp++; if ({busy, mem_req, pc} !== {2'b00, 16'h0003}) begin n_fail++; $display("FAIL step_restall got busy=%b req=%b pc=%h want 0 0 0003", busy, mem_req, pc); end
    halt = 1'b0;
  endtask

  task automatic test_reset_mid();
    irin = 8'h70; uc0 = 8'h80; uc1 = 8'h00;
    advance_to(WAIT_MEM, 0);
    rst = 1'b1;
    #1;
    n_cmp++; if ({mem_req, busy, pc} !== {2'b00, 16'h0000}) begin n_fail++; $display("FAIL rst_mid got req=%b busy=%b pc=%h want 0 0 0000", mem_req, busy, pc); end
    @(posedge clk); rst = 1'b0; mem_done = 1'b0;
    run_instr(8'h71, 8'h00, 8'h00, 0);
    n_cmp++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL rst_first_fetch got %h want 0001", pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand();
    test_jump_irq();
    test_wrap();
    test_halt();
    test_step();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
